// File: rtl/pair_atom_pkg.sv
// Shared types, address constants and field widths for the pair-atom controller.
package pair_atom_pkg;

    typedef logic [31:0] int32_t;
    typedef logic [1:0]  int2_t;
    typedef logic        bool;

    localparam int ADDR_SEL_W = 19;
    localparam int ADDR_SEL_B = 20;

    localparam int SEL_B_W  = 17;
    localparam int SEL_W_W  = 32;
    localparam int REL_OP_W = 6;
    localparam int CONS_W   = 608;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        DRAIN  = 2'd1,
        SWAP   = 2'd2
    } state_t;

endpackage

// File: rtl/pair_cfg_bank.sv
// Shadow/active configuration bank: decodes config writes into the shadow copy,
// flags writes to unmapped addresses, and copies shadow to active on swap.
module pair_cfg_bank
    import pair_atom_pkg::*;
#(
    parameter int NUM_CONS = 19,
    parameter int CFG_AW   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_wr,
    input  logic [CFG_AW-1:0]        cfg_addr,
    input  logic [31:0]              cfg_wdata,
    input  logic                     swap,
    output logic                     cfg_err,
    output logic [32*NUM_CONS-1:0]   cfg_cons,
    output logic [SEL_B_W-1:0]       cfg_sel_b,
    output logic [SEL_W_W-1:0]       cfg_sel_w,
    output logic [REL_OP_W-1:0]      cfg_rel_op
);

    int32_t                sh_cons_q  [NUM_CONS];
    int32_t                sh_cons_d  [NUM_CONS];
    int32_t                act_cons_q [NUM_CONS];
    int32_t                act_cons_d [NUM_CONS];
    logic [SEL_W_W-1:0]    sh_sel_w_q, sh_sel_w_d, act_sel_w_q, act_sel_w_d;
    logic [SEL_B_W-1:0]    sh_sel_b_q, sh_sel_b_d, act_sel_b_q, act_sel_b_d;
    logic [REL_OP_W-1:0]   sh_rel_q, sh_rel_d, act_rel_q, act_rel_d;
    bool                   err_q, err_d;
    bool                   wr_sel_w, wr_sel_b, wr_bad;

    assign wr_sel_w = cfg_wr && (cfg_addr == CFG_AW'(ADDR_SEL_W));
    assign wr_sel_b = cfg_wr && (cfg_addr == CFG_AW'(ADDR_SEL_B));
    assign wr_bad   = cfg_wr && (int'(cfg_addr) > ADDR_SEL_B);

    // The swap reads the registered shadow, so a write in the swap cycle lands after the copy.
    always_comb begin
        for (int i = 0; i < NUM_CONS; i++) begin
            sh_cons_d[i]  = (cfg_wr && (int'(cfg_addr) == i)) ? cfg_wdata : sh_cons_q[i];
            act_cons_d[i] = swap ? sh_cons_q[i] : act_cons_q[i];
        end
        sh_sel_w_d  = wr_sel_w ? cfg_wdata : sh_sel_w_q;
        sh_sel_b_d  = wr_sel_b ? cfg_wdata[SEL_B_W-1:0] : sh_sel_b_q;
        sh_rel_d    = wr_sel_b ? cfg_wdata[SEL_B_W+REL_OP_W-1:SEL_B_W] : sh_rel_q;
        act_sel_w_d = swap ? sh_sel_w_q : act_sel_w_q;
        act_sel_b_d = swap ? sh_sel_b_q : act_sel_b_q;
        act_rel_d   = swap ? sh_rel_q : act_rel_q;
        err_d       = wr_bad ? 1'b1 : (swap ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CONS; i++) begin
                sh_cons_q[i]  <= '0;
                act_cons_q[i] <= '0;
            end
            sh_sel_w_q  <= '0;
            sh_sel_b_q  <= '0;
            sh_rel_q    <= '0;
            act_sel_w_q <= '0;
            act_sel_b_q <= '0;
            act_rel_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CONS; i++) begin
                sh_cons_q[i]  <= sh_cons_d[i];
                act_cons_q[i] <= act_cons_d[i];
            end
            sh_sel_w_q  <= sh_sel_w_d;
            sh_sel_b_q  <= sh_sel_b_d;
            sh_rel_q    <= sh_rel_d;
            act_sel_w_q <= act_sel_w_d;
            act_sel_b_q <= act_sel_b_d;
            act_rel_q   <= act_rel_d;
            err_q       <= err_d;
        end
    end

    for (genvar gi = 0; gi < NUM_CONS; gi++) begin : g_cons
        assign cfg_cons[32*gi +: 32] = act_cons_q[gi];
    end

    assign cfg_sel_w  = act_sel_w_q;
    assign cfg_sel_b  = act_sel_b_q;
    assign cfg_rel_op = act_rel_q;
    assign cfg_err    = err_q;

endmodule

// File: rtl/pair_atom_ctrl.sv
// Commit FSM and packet issue path for one pair atom.
// Optional feature macro: PAIR_CTRL_CLR_ON_COMMIT_EN (adds commit_clr / atom_clr).
module pair_atom_ctrl
    import pair_atom_pkg::*;
#(
    parameter int NUM_CONS = 19,
    parameter int CFG_AW   = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_wr,
    input  logic [CFG_AW-1:0]        cfg_addr,
    input  logic [31:0]              cfg_wdata,
    output logic                     cfg_err,
    input  logic                     commit_req,
    output logic                     commit_busy,
    output logic                     commit_done,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pkt_1,
    input  logic [31:0]              in_pkt_2,
    output logic                     atom_en,
    output logic [31:0]              atom_pkt_1,
    output logic [31:0]              atom_pkt_2,
    input  logic [31:0]              atom_read_1,
    input  logic [31:0]              atom_read_2,
    output logic [32*NUM_CONS-1:0]   cfg_cons,
    output logic [SEL_B_W-1:0]       cfg_sel_b,
    output logic [SEL_W_W-1:0]       cfg_sel_w,
    output logic [REL_OP_W-1:0]      cfg_rel_op,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_read_1,
    output logic [31:0]              out_read_2,
    output logic [31:0]              pkt_count
`ifdef PAIR_CTRL_CLR_ON_COMMIT_EN
    ,
    input  logic                     commit_clr,
    output logic                     atom_clr
`endif
);

    state_t state_q, state_d;
    bool    out_valid_q, out_valid_d;
    int32_t out_read_1_q, out_read_1_d;
    int32_t out_read_2_q, out_read_2_d;
    int32_t pkt_count_q, pkt_count_d;
    bool    fire, swap;

    pair_cfg_bank #(
        .NUM_CONS (NUM_CONS),
        .CFG_AW   (CFG_AW)
    ) u_bank (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_wr     (cfg_wr),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .swap       (swap),
        .cfg_err    (cfg_err),
        .cfg_cons   (cfg_cons),
        .cfg_sel_b  (cfg_sel_b),
        .cfg_sel_w  (cfg_sel_w),
        .cfg_rel_op (cfg_rel_op)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACTIVE:  if (commit_req) state_d = DRAIN;
            DRAIN:   if (!out_valid_q) state_d = SWAP;
            SWAP:    state_d = ACTIVE;
            default: state_d = ACTIVE;
        endcase
    end

    assign swap        = (state_q == SWAP);
    assign commit_busy = (state_q != ACTIVE);
    assign commit_done = swap;

    // Held low through reset so nothing upstream fires into an atom that is being reset.
    assign in_ready   = rst_n && (state_q == ACTIVE) && (!out_valid_q || out_ready);
    assign fire       = in_valid && in_ready;
    assign atom_en    = fire;
    assign atom_pkt_1 = in_pkt_1;
    assign atom_pkt_2 = in_pkt_2;

    always_comb begin
        out_valid_d  = fire || (out_valid_q && !out_ready);
        out_read_1_d = fire ? atom_read_1 : out_read_1_q;
        out_read_2_d = fire ? atom_read_2 : out_read_2_q;
        pkt_count_d  = swap ? '0 : (fire ? pkt_count_q + 32'd1 : pkt_count_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ACTIVE;
            out_valid_q  <= 1'b0;
            out_read_1_q <= '0;
            out_read_2_q <= '0;
            pkt_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            out_valid_q  <= out_valid_d;
            out_read_1_q <= out_read_1_d;
            out_read_2_q <= out_read_2_d;
            pkt_count_q  <= pkt_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_read_1 = out_read_1_q;
    assign out_read_2 = out_read_2_q;
    assign pkt_count  = pkt_count_q;

`ifdef PAIR_CTRL_CLR_ON_COMMIT_EN
    bool commit_clr_q, commit_clr_d;

    always_comb begin
        commit_clr_d = ((state_q == ACTIVE) && commit_req) ? commit_clr : commit_clr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) commit_clr_q <= 1'b0;
        else        commit_clr_q <= commit_clr_d;
    end

    assign atom_clr = swap && commit_clr_q;
`endif

endmodule
